// File: rtl/path_replayer.sv
// path_replayer
// Drains the location queue after the maze search finishes and turns each
// consecutive pair of {x, y} locations into a single-step move command
// (up/right/down/left) on a valid/ready interface. A step that is not one of
// the four unit moves aborts the replay with a sticky error.
module path_replayer #(
    parameter int XW    = 4,
    parameter int YW    = 4,
    parameter int CNT_W = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic                 stk_empty,
    input  logic [XW+YW-1:0]     stk_loc,
    output logic                 stk_pop,
    output logic                 mv_valid,
    input  logic                 mv_ready,
    output logic [1:0]           mv_dir,
    output logic [XW+YW-1:0]     mv_loc,
    output logic                 busy,
    output logic                 fin,
    output logic                 err,
    output logic [CNT_W-1:0]     num_moves
);

    localparam int LW = XW + YW;

    localparam logic [2:0] IDLE = 3'd0;
    localparam logic [2:0] POP  = 3'd1;
    localparam logic [2:0] CAP  = 3'd2;
    localparam logic [2:0] EMIT = 3'd3;
    localparam logic [2:0] FIN  = 3'd4;

    localparam logic [1:0] DIR_UP    = 2'b00;
    localparam logic [1:0] DIR_RIGHT = 2'b01;
    localparam logic [1:0] DIR_DOWN  = 2'b10;
    localparam logic [1:0] DIR_LEFT  = 2'b11;

    // Classifies a signed coordinate delta. Result is {legal, direction};
    // anything other than a single unit step (including no motion and
    // diagonals) comes back with legal cleared.
    function automatic logic [2:0] stepDecode(input logic [XW:0] dx, input logic [YW:0] dy);
        logic [2:0] res;
        res = 3'b000;
        if ((dx == {(XW+1){1'b0}}) && (dy == {(YW+1){1'b1}})) begin
            res = {1'b1, DIR_UP};
        end else if ((dx == {{XW{1'b0}}, 1'b1}) && (dy == {(YW+1){1'b0}})) begin
            res = {1'b1, DIR_RIGHT};
        end else if ((dx == {(XW+1){1'b0}}) && (dy == {{YW{1'b0}}, 1'b1})) begin
            res = {1'b1, DIR_DOWN};
        end else if ((dx == {(XW+1){1'b1}}) && (dy == {(YW+1){1'b0}})) begin
            res = {1'b1, DIR_LEFT};
        end else begin
            res = 3'b000;
        end
        return res;
    endfunction

    logic [2:0]       state_r;
    logic [2:0]       nextState_s;
    logic [LW-1:0]    prevLoc_r;
    logic             first_r;
    logic             mvValid_r;
    logic [1:0]       mvDir_r;
    logic [LW-1:0]    mvLoc_r;
    logic             busy_r;
    logic             fin_r;
    logic             err_r;
    logic [CNT_W-1:0] numMoves_r;

    logic [XW:0]      dx_s;
    logic [YW:0]      dy_s;
    logic [2:0]       step_s;
    logic             stepOk_s;
    logic             handshake_s;
    logic             startAcc_s;

    // Zero-extend both coordinates by one bit so the difference is an exact
    // signed value; coordinates never wrap around the grid edge.
    assign dx_s = {1'b0, stk_loc[LW-1:YW]} - {1'b0, prevLoc_r[LW-1:YW]};
    assign dy_s = {1'b0, stk_loc[YW-1:0]}  - {1'b0, prevLoc_r[YW-1:0]};
    assign step_s   = stepDecode(dx_s, dy_s);
    assign stepOk_s = step_s[2];

    assign handshake_s = (state_r == EMIT) && mvValid_r && mv_ready;
    assign startAcc_s  = (state_r == IDLE) && start;

    // The pop request depends on the live empty flag so it can never be
    // raised against an empty queue.
    assign stk_pop = (state_r == POP) && !stk_empty;

    assign mv_valid  = mvValid_r;
    assign mv_dir    = mvDir_r;
    assign mv_loc    = mvLoc_r;
    assign busy      = busy_r;
    assign fin       = fin_r;
    assign err       = err_r;
    assign num_moves = numMoves_r;

    // Next-state decode for the replay sequencer.
    always_comb begin
        nextState_s = state_r;
        case (state_r)
            IDLE: begin
                if (start) begin
                    nextState_s = POP;
                end else begin
                    nextState_s = IDLE;
                end
            end
            POP: begin
                if (stk_empty) begin
                    nextState_s = FIN;
                end else begin
                    nextState_s = CAP;
                end
            end
            CAP: begin
                if (first_r) begin
                    nextState_s = POP;
                end else if (stepOk_s) begin
                    nextState_s = EMIT;
                end else begin
                    nextState_s = FIN;
                end
            end
            EMIT: begin
                if (handshake_s) begin
                    nextState_s = POP;
                end else begin
                    nextState_s = EMIT;
                end
            end
            FIN: begin
                nextState_s = IDLE;
            end
            default: begin
                nextState_s = IDLE;
            end
        endcase
    end

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r <= IDLE;
        end else begin
            state_r <= nextState_s;
        end
    end

    // Previous-location tracking and the start-cell flag.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            prevLoc_r <= {LW{1'b0}};
            first_r   <= 1'b1;
        end else if (startAcc_s) begin
            first_r   <= 1'b1;
        end else if (state_r == CAP) begin
            if (first_r || stepOk_s) begin
                prevLoc_r <= stk_loc;
            end else begin
                prevLoc_r <= prevLoc_r;
            end
            first_r <= 1'b0;
        end else begin
            prevLoc_r <= prevLoc_r;
            first_r   <= first_r;
        end
    end

    // Move command register: loaded on a legal step, held until accepted.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mvValid_r <= 1'b0;
            mvDir_r   <= 2'b00;
            mvLoc_r   <= {LW{1'b0}};
        end else if ((state_r == CAP) && !first_r && stepOk_s) begin
            mvValid_r <= 1'b1;
            mvDir_r   <= step_s[1:0];
            mvLoc_r   <= stk_loc;
        end else if (handshake_s) begin
            mvValid_r <= 1'b0;
        end else begin
            mvValid_r <= mvValid_r;
        end
    end

    // Busy flag and the one-cycle completion pulse.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            busy_r <= 1'b0;
            fin_r  <= 1'b0;
        end else begin
            fin_r <= (nextState_s == FIN);
            if (startAcc_s) begin
                busy_r <= 1'b1;
            end else if (state_r == FIN) begin
                busy_r <= 1'b0;
            end else begin
                busy_r <= busy_r;
            end
        end
    end

    // Sticky path error and saturating accepted-move counter.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            err_r      <= 1'b0;
            numMoves_r <= {CNT_W{1'b0}};
        end else if (startAcc_s) begin
            err_r      <= 1'b0;
            numMoves_r <= {CNT_W{1'b0}};
        end else if ((state_r == CAP) && !first_r && !stepOk_s) begin
            err_r <= 1'b1;
        end else if (handshake_s) begin
            if (numMoves_r != {CNT_W{1'b1}}) begin
                numMoves_r <= numMoves_r + {{(CNT_W-1){1'b0}}, 1'b1};
            end else begin
                numMoves_r <= numMoves_r;
            end
        end else begin
            err_r      <= err_r;
            numMoves_r <= numMoves_r;
        end
    end

endmodule

// File: tb/tb_path_replayer.sv
// Directed bench for path_replayer: a small queue model feeds locations,
// moves are recorded at the handshake and compared to hand-derived lists.
module tb_path_replayer;

    logic       clk = 1'b0;
    logic       rst;
    logic       start;
    logic       stk_empty;
    logic [7:0] stk_loc;
    logic       stk_pop;
    logic       mv_valid;
    logic       mv_ready;
    logic [1:0] mv_dir;
    logic [7:0] mv_loc;
    logic       busy;
    logic       fin;
    logic       err;
    logic [7:0] num_moves;

    int total = 0;
    int bad   = 0;

    logic [7:0] pathMem [0:299];
    int pathLen;
    int pathIdx;
    int popCount;
    int moveCount;
    int finCount;
    int popWhileEmpty;
    logic [1:0] gotDir [0:15];
    logic [7:0] gotLoc [0:15];

    path_replayer #(.XW(4), .YW(4), .CNT_W(8)) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .stk_empty (stk_empty),
        .stk_loc   (stk_loc),
        .stk_pop   (stk_pop),
        .mv_valid  (mv_valid),
        .mv_ready  (mv_ready),
        .mv_dir    (mv_dir),
        .mv_loc    (mv_loc),
        .busy      (busy),
        .fin       (fin),
        .err       (err),
        .num_moves (num_moves)
    );

    always #5 clk = ~clk;

    task automatic loadPath(input int len);
        pathLen       = len;
        pathIdx       = 0;
        stk_empty     = (len == 0);
        popCount      = 0;
        moveCount     = 0;
        finCount      = 0;
        popWhileEmpty = 0;
    endtask

    // Called at a falling edge: observe, cross one rising edge, update the queue.
    task automatic stepCycle();
        logic doPop;
        doPop = stk_pop && !stk_empty;
        if (stk_pop && stk_empty) popWhileEmpty++;
        if (stk_pop) popCount++;
        if (mv_valid && mv_ready) begin
            if (moveCount < 16) begin
                gotDir[moveCount] = mv_dir;
                gotLoc[moveCount] = mv_loc;
            end
            moveCount++;
        end
        if (fin) finCount++;
        @(posedge clk);
        #1;
        if (doPop) begin
            stk_loc   = pathMem[pathIdx];
            pathIdx++;
            stk_empty = (pathIdx >= pathLen);
        end
        @(negedge clk);
    endtask

    task automatic pulseStart();
        start = 1'b1;
        stepCycle();
        start = 1'b0;
    endtask

    task automatic runUntilFin(input int budget, input string name);
        int f0;
        int c;
        f0 = finCount;
        c  = 0;
        while ((finCount == f0) && (c < budget)) begin
            stepCycle();
            c++;
        end
        total++;
        if (finCount == f0) begin
            bad++;
            $display("FAIL %s: fin not seen within %0d cycles", name, budget);
        end
    endtask

    task automatic test_reset();
        total++;
        if ({stk_pop, mv_valid, mv_dir, mv_loc, busy, fin, err, num_moves} !== 23'd0) begin
            bad++;
            $display("FAIL reset_outputs: got %h want 0",
                     {stk_pop, mv_valid, mv_dir, mv_loc, busy, fin, err, num_moves});
        end
    endtask

    task automatic test_empty();
        loadPath(0);
        pulseStart();
        total++;
        if ({stk_pop, fin, busy} !== 3'b001) begin
            bad++;
            $display("FAIL empty_pop_cycle: got pop,fin,busy=%b want 001", {stk_pop, fin, busy});
        end
        stepCycle();
        total++;
        if (fin !== 1'b1) begin
            bad++;
            $display("FAIL empty_fin: got %b want 1", fin);
        end
        stepCycle();
        total++;
        if ({fin, busy, err, num_moves} !== 11'd0 || popCount != 0) begin
            bad++;
            $display("FAIL empty_final: got fin,busy,err,num=%b,%b,%b,%0d pops=%0d want all 0",
                     fin, busy, err, num_moves, popCount);
        end
    endtask

    task automatic loadSquare();
        pathMem[0] = 8'h00; pathMem[1] = 8'h10; pathMem[2] = 8'h11;
        pathMem[3] = 8'h01; pathMem[4] = 8'h00;
        loadPath(5);
    endtask

    task automatic checkSquareMoves(input string name);
        logic [1:0] expDir [0:3];
        logic [7:0] expLoc [0:3];
        expDir = '{2'b01, 2'b10, 2'b11, 2'b00};
        expLoc = '{8'h10, 8'h11, 8'h01, 8'h00};
        total++;
        if (moveCount != 4 || popCount != 5 || popWhileEmpty != 0) begin
            bad++;
            $display("FAIL %s_counts: got moves=%0d pops=%0d popEmpty=%0d want 4 5 0",
                     name, moveCount, popCount, popWhileEmpty);
        end
        for (int i = 0; i < 4; i++) begin
            total++;
            if (gotDir[i] !== expDir[i] || gotLoc[i] !== expLoc[i]) begin
                bad++;
                $display("FAIL %s_move%0d: got dir=%b loc=%h want dir=%b loc=%h",
                         name, i, gotDir[i], gotLoc[i], expDir[i], expLoc[i]);
            end
        end
        total++;
        if (num_moves !== 8'd4 || err !== 1'b0 || busy !== 1'b0) begin
            bad++;
            $display("FAIL %s_status: got num=%0d err=%b busy=%b want 4 0 0",
                     name, num_moves, err, busy);
        end
    endtask

    task automatic test_path();
        loadSquare();
        mv_ready = 1'b1;
        pulseStart();
        runUntilFin(100, "path_fin");
        checkSquareMoves("path");
    endtask

    task automatic test_backpressure();
        int c;
        loadSquare();
        mv_ready = 1'b1;
        pulseStart();
        c = 0;
        while (!(moveCount == 1 && mv_valid) && c < 100) begin
            stepCycle();
            c++;
        end
        total++;
        if (!(moveCount == 1 && mv_valid)) begin
            bad++;
            $display("FAIL bp_reach: second move not offered, moves=%0d", moveCount);
        end
        mv_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            total++;
            if ({mv_valid, mv_dir, mv_loc, stk_pop} !== {1'b1, 2'b10, 8'h11, 1'b0}) begin
                bad++;
                $display("FAIL bp_stall%0d: got valid=%b dir=%b loc=%h pop=%b want 1 10 11 0",
                         i, mv_valid, mv_dir, mv_loc, stk_pop);
            end
            stepCycle();
        end
        mv_ready = 1'b1;
        runUntilFin(100, "bp_fin");
        checkSquareMoves("bp");
    endtask

    task automatic test_nonadjacent();
        pathMem[0] = 8'h22; pathMem[1] = 8'h44;
        loadPath(2);
        pulseStart();
        runUntilFin(50, "nonadj_fin");
        total++;
        if (moveCount != 0 || err !== 1'b1 || popCount != 2 || num_moves !== 8'd0) begin
            bad++;
            $display("FAIL nonadj: got moves=%0d err=%b pops=%0d num=%0d want 0 1 2 0",
                     moveCount, err, popCount, num_moves);
        end
        pathMem[0] = 8'hF0; pathMem[1] = 8'h00;
        loadPath(2);
        pulseStart();
        runUntilFin(50, "wrap_fin");
        total++;
        if (moveCount != 0 || err !== 1'b1) begin
            bad++;
            $display("FAIL wrap: got moves=%0d err=%b want 0 1", moveCount, err);
        end
        loadPath(0);
        pulseStart();
        total++;
        if (err !== 1'b0) begin
            bad++;
            $display("FAIL err_clear: got %b want 0", err);
        end
        runUntilFin(20, "clear_fin");
    endtask

    task automatic test_single();
        pathMem[0] = 8'h35;
        loadPath(1);
        pulseStart();
        runUntilFin(50, "single_fin");
        total++;
        if (popCount != 1 || moveCount != 0 || err !== 1'b0 || num_moves !== 8'd0) begin
            bad++;
            $display("FAIL single: got pops=%0d moves=%0d err=%b num=%0d want 1 0 0 0",
                     popCount, moveCount, err, num_moves);
        end
    endtask

    task automatic test_saturation();
        for (int i = 0; i < 257; i++) begin
            pathMem[i] = (i % 2 == 0) ? 8'h00 : 8'h10;
        end
        loadPath(257);
        mv_ready = 1'b1;
        pulseStart();
        runUntilFin(1200, "sat_fin");
        total++;
        if (num_moves !== 8'hFF || moveCount != 256 || err !== 1'b0) begin
            bad++;
            $display("FAIL saturation: got num=%0d moves=%0d err=%b want 255 256 0",
                     num_moves, moveCount, err);
        end
    endtask

    task automatic test_reset_mid();
        int c;
        pathMem[0] = 8'h00; pathMem[1] = 8'h10;
        loadPath(2);
        mv_ready = 1'b0;
        pulseStart();
        c = 0;
        while (!mv_valid && c < 20) begin
            stepCycle();
            c++;
        end
        start = 1'b1;
        stepCycle();
        start = 1'b0;
        total++;
        if ({mv_valid, busy, mv_dir, mv_loc, num_moves} !== {1'b1, 1'b1, 2'b01, 8'h10, 8'd0}) begin
            bad++;
            $display("FAIL emit_hold: got valid=%b busy=%b dir=%b loc=%h num=%0d want 1 1 01 10 0",
                     mv_valid, busy, mv_dir, mv_loc, num_moves);
        end
        #2;
        rst = 1'b1;
        #1;
        test_reset();
        @(negedge clk);
        rst = 1'b0;
        pathMem[0] = 8'h00; pathMem[1] = 8'h10;
        loadPath(2);
        for (int i = 0; i < 3; i++) stepCycle();
        total++;
        if (popCount != 0 || busy !== 1'b0 || mv_valid !== 1'b0) begin
            bad++;
            $display("FAIL post_reset_idle: got pops=%0d busy=%b valid=%b want 0 0 0",
                     popCount, busy, mv_valid);
        end
    endtask

    initial begin
        rst       = 1'b1;
        start     = 1'b0;
        mv_ready  = 1'b0;
        stk_empty = 1'b1;
        stk_loc   = 8'h00;
        loadPath(0);
        #2;
        test_reset();
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        test_empty();
        test_path();
        test_backpressure();
        test_nonadjacent();
        test_single();
        test_saturation();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/path_replayer.md
Name: path_replayer

Overview:
- Drains the location stack/queue after the maze search asserts done, which puts the stack in queue (FIFO) pop order.
- Each popped 8-bit location is {x[3:0], y[3:0]}. The block compares it against the previous location and produces a one-step move command (up/right/down/left) on a valid/ready interface to the motion/display logic.
- Sits between the location stack's read side and the downstream move consumer.
- Reports the move count, completion and path errors.

Parameters:
- XW, 4, x-coordinate width (loc bits [XW+YW-1:YW])
- YW, 4, y-coordinate width (loc bits [YW-1:0])
- CNT_W, 8, move counter width

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  asynchronous, active-high reset
- start  in  1  1-cycle pulse: begin replay (issued after stack done)
- stk_empty  in  1  stack empty flag (queue mode: main==head)
- stk_loc  in  XW+YW  stack locOut; valid the cycle after pop was sampled
- stk_pop  out  1  1-cycle pop request to stack
- mv_valid  out  1  move command valid
- mv_ready  in  1  consumer accepts move
- mv_dir  out  2  00 up (y-1), 01 right (x+1), 10 down (y+1), 11 left (x-1)
- mv_loc  out  XW+YW  destination location of the move
- busy  out  1  replay in progress
- fin  out  1  1-cycle pulse when replay ends (normal or error)
- err  out  1  sticky: non-adjacent step seen; cleared by next accepted start
- num_moves  out  CNT_W  moves accepted this replay, saturating

Behaviour:
- Reset (async): state IDLE; stk_pop=0, mv_valid=0, mv_dir=0, mv_loc=0, busy=0, fin=0, err=0, num_moves=0, prev=0, first=1.
- States: IDLE, POP, CAP, EMIT, FIN.
- IDLE:
  - start=1 -> POP; clear err and num_moves; set first=1; busy=1 from the next cycle.
  - start is ignored in every other state.
- POP:
  - If stk_empty=1: no pop, -> FIN.
  - Else: drive stk_pop=1 for exactly this cycle, -> CAP.
  - stk_pop is never asserted while stk_empty=1.
- CAP: sample stk_loc (the stack updated locOut on the pop edge).
  - If first=1: prev<=stk_loc, first<=0, -> POP. No move is emitted for the start cell.
  - Else compute dx=x_new-x_prev and dy=y_new-y_prev (signed, XW+1/YW+1 bits):
    - (0,-1)->00, (+1,0)->01, (0,+1)->10, (-1,0)->11. Load mv_dir and mv_loc=stk_loc, set prev<=stk_loc, -> EMIT.
    - Any other delta, including (0,0) and diagonals: err<=1, -> FIN. No move is emitted.
- EMIT:
  - mv_valid=1, with mv_dir and mv_loc held stable until the handshake.
  - On mv_valid&&mv_ready: num_moves+1 (saturates at all-ones), mv_valid=0 next cycle, -> POP.
  - mv_ready may be held high constantly; the minimum cost is 3 cycles per move (POP, CAP, EMIT).
- FIN: fin=1 for one cycle, busy=0 next cycle, -> IDLE. err and num_moves hold until the next start.
- Coordinates never wrap: x=15->0 counts as dx=-15 and flags err.
- rst mid-replay aborts immediately and forces all outputs to their reset values. An outstanding move is dropped; the stack is expected to be reset alongside.
- stk_loc is not sampled in any state other than CAP.

Test Plan:
- Empty stack: stk_empty=1, start -> no stk_pop; fin pulses 2 cycles after start; num_moves=0, err=0.
- Path 0x00,0x10,0x11,0x01,0x00 with mv_ready=1 -> 5 pops; moves right(01,0x10), down(10,0x11), left(11,0x01), up(00,0x00); num_moves=4, fin=1, err=0.
- Backpressure: same path, mv_ready low for 5 cycles on the 2nd move -> mv_valid, mv_dir=10 and mv_loc=0x11 stay stable; no stk_pop during the stall; final num_moves=4.
- Non-adjacent: 0x22 then 0x44 -> no move emitted, err=1, fin pulses; a later start clears err.
- Single cell: one location 0x35, then empty -> 1 pop, 0 moves, fin=1, err=0.
- Reset during EMIT (mv_valid=1) -> all outputs 0 asynchronously, state IDLE; start while busy is ignored.
